demux_8_reg: RTL and testbench
==============================

// Module: demux_8_reg
// PURPOSE
//  1-to-8 registered demultiplexer; the write-side counterpart of the 8:1 selector Mux_8.
//  Accepts one WIDTH-bit word per cycle from a single source and steers it to one of 8 channel
//  holding registers, by explicit addr or by an internal round-robin pointer.
//  Sits between a shared data path and 8 independent consumers; valid/ready on both sides.
// PARAMETERS
//  WIDTH  8  data word width in bits (legal: 1..64)
//  NCH    8  channel count; fixed at 8 (3-bit addr); not to be overridden
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous reset, active-high
//  ncs        in   1          chip select, active-low; 1 = block ignores input
//  auto_inc   in   1          1 = route by internal pointer, 0 = route by addr
//  addr       in   3          target channel when auto_inc=0 (3'b000 = ch0 ... 3'b111 = ch7)
//  din        in   WIDTH      input word
//  din_valid  in   1          din/addr qualified
//  din_ready  out  1          block can accept this cycle
//  dout_bus   out  8*WIDTH    channel k data at [k*WIDTH +: WIDTH]
//  dout_valid out  8          bit k: channel k holds a word
//  dout_ready in   8          bit k: consumer k takes word this cycle
//  ptr        out  3          current round-robin pointer (status)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): dout_valid=0, dout_bus=0, ptr=0; din_ready=0 while rst=1.
//  Target sel = auto_inc ? ptr : addr (combinational, same cycle as din_valid).
//  Channel k "free" = !dout_valid[k] | dout_ready[k] (drain and refill same cycle allowed).
//  din_ready = !rst & !ncs & free[sel]  (combinational; no dependence on din_valid).
//  Accept = din_valid & din_ready. On accept: channel sel loads din, dout_valid[sel]<=1 next edge.
//  Latency: din accepted at edge N -> visible on dout_bus/dout_valid after edge N (1 cycle).
//  Drain: dout_valid[k] & dout_ready[k] & !(accept into k) -> dout_valid[k]<=0; data held (not cleared).
//  Simultaneous drain+accept on same channel: dout_valid[k] stays 1, data = new din; no bubble.
//  Non-target channels unaffected by accept; all 8 channels drain independently each cycle.
//  ptr advances (ptr+1, wraps 7->0) only on accept with auto_inc=1; held otherwise.
//  auto_inc=0 accepts never move ptr; toggling auto_inc does not reset ptr.
//  ncs=1: no accepts, din_ready=0; held channels still drain normally; ptr held.
//  Target full & not draining: din_ready=0, source stalls; in auto mode no skipping to free channel
//  (strict order preserved).
//  rst mid-operation: all held words discarded, no dout_valid pulse after reset edge.
//  dout_ready on an invalid channel is ignored. X on addr is don't-care when auto_inc=1.
// STRUCTURE
//  Shared include (demux_defs.vh): `DMX_NCH=8, `DMX_SELW=3, channel-slice macro for dout_bus.
//  Sub-module demux_chan_reg (WIDTH param): one-entry holding register with load/valid/ready;
//  instantiated 8x via generate. Top holds sel mux, ptr counter, din_ready logic (~150 lines).
// TESTING
//  1 Reset: drive rst=1 2 cycles with din_valid=1 -> dout_valid=8'h00, ptr=0, din_ready=0.
//  2 Addressed: auto_inc=0, addr=3'b101, din=8'hA5, dout_ready=0 -> next cycle dout_valid=8'h20,
//    dout_bus[47:40]=8'hA5; second word to addr 5 -> din_ready=0 until dout_ready[5]=1.
//  3 Round-robin: auto_inc=1, 10 words 8'h00..8'h09, all dout_ready=1 -> ch0..ch7 get 00..07,
//    ch0,ch1 get 08,09; ptr ends at 2.
//  4 Back-pressure: auto_inc=1, dout_ready=0, 9 words offered -> 8 accepted, dout_valid=8'hFF,
//    din_ready=0 with ptr=0; raise dout_ready[0] -> 9th word lands in ch0 same cycle, no bubble.
//  5 Chip select: ncs=1 with din_valid=1 for 4 cycles -> no accepts, ptr unchanged, held words
//    in ch2 still drain on dout_ready[2]=1.
//  6 Reset mid-run: rst=1 while dout_valid=8'h0F -> next cycle dout_valid=0, ptr=0; first post-reset
//    auto word goes to ch0.

Source files
------------

// File: rtl/demux_8_reg_pkg.sv
// ============================================================================
// Module  : demux_8_reg_pkg
// Brief   : Shared constants and helpers for the 1-to-8 registered demux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_8_reg_pkg;

    localparam int DMX_NCH  = 8;
    localparam int DMX_SELW = 3;

    typedef logic [DMX_SELW-1:0] dmx_sel_t;

    // Pointer advance wraps naturally through the 3-bit width.
    function automatic dmx_sel_t dmx_next_ptr(input dmx_sel_t cur);
        return cur + dmx_sel_t'(1);
    endfunction

endpackage : demux_8_reg_pkg

`default_nettype wire

// File: rtl/demux_8_reg_chan.sv
// ============================================================================
// Module  : demux_8_reg_chan
// Brief   : One-entry channel holding register with load / valid / ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_8_reg_chan
    import demux_8_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             free_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    // Drained data is held, only the valid flag drops; a load wins over a drain.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = din_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign free_o  = !valid_q || ready_i;

endmodule : demux_8_reg_chan

`default_nettype wire

// File: rtl/demux_8_reg.sv
// ============================================================================
// Module  : demux_8_reg
// Brief   : 1-to-8 registered demultiplexer, addressed or round-robin routing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_8_reg
    import demux_8_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = DMX_NCH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ncs,
    input  logic                 auto_inc,
    input  logic [DMX_SELW-1:0]  addr,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [NCH*WIDTH-1:0] dout_bus,
    output logic [NCH-1:0]       dout_valid,
    input  logic [NCH-1:0]       dout_ready,
    output logic [DMX_SELW-1:0]  ptr
);

    dmx_sel_t       ptr_q;
    dmx_sel_t       ptr_d;
    dmx_sel_t       w_sel;
    logic [NCH-1:0] w_free;
    logic [NCH-1:0] w_load;
    logic           w_accept;

    assign w_sel     = auto_inc ? ptr_q : addr;
    assign din_ready = !rst && !ncs && w_free[w_sel];
    assign w_accept  = din_valid && din_ready;

    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load[w_sel] = 1'b1;
        end
    end

    // Strict order in auto mode: the pointer only moves on an actual accept.
    always_comb begin
        ptr_d = ptr_q;
        if (w_accept && auto_inc) begin
            ptr_d = dmx_next_ptr(ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_chan
            demux_8_reg_chan #(
                .WIDTH (WIDTH)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .load_i  (w_load[k]),
                .din_i   (din),
                .ready_i (dout_ready[k]),
                .data_o  (dout_bus[k*WIDTH +: WIDTH]),
                .valid_o (dout_valid[k]),
                .free_o  (w_free[k])
            );
        end
    endgenerate

endmodule : demux_8_reg

`default_nettype wire

// File: tb/tb_demux_8_reg.sv
// ============================================================================
// Module  : tb_demux_8_reg
// Brief   : Self-checking bench for demux_8_reg against a channel-array model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_8_reg;

    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ncs = 1'b0;
    logic        auto_inc = 1'b0;
    logic [2:0]  addr = '0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [63:0] dout_bus;
    logic [7:0]  dout_valid;
    logic [7:0]  dout_ready = '0;
    logic [2:0]  ptr;

    int n_chk = 0;
    int n_err = 0;

    // Model: eight channel slots plus the round-robin pointer.
    logic [7:0] m_vld;
    logic [7:0] m_dat [8];
    int         m_ptr;
    logic       last_rdy;

    demux_8_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ncs        (ncs),
        .auto_inc   (auto_inc),
        .addr       (addr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_bus   (dout_bus),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ptr        (ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_bus();
        logic [63:0] b;
        for (int k = 0; k < 8; k++) b[k*8 +: 8] = m_dat[k];
        return b;
    endfunction

    // One clock: drive inputs, compare every output with the model, clock, update model.
    task automatic cyc(input logic r, input logic cs_n, input logic ai, input logic [2:0] a,
                       input logic [7:0] d, input logic dv, input logic [7:0] dr);
        int   tgt;
        logic exp_rdy;
        @(negedge clk);
        rst = r; ncs = cs_n; auto_inc = ai; addr = a; din = d; din_valid = dv; dout_ready = dr;
        #1;
        tgt     = ai ? m_ptr : int'(a);
        exp_rdy = !r && !cs_n && (!m_vld[tgt] || dr[tgt]);
        last_rdy = din_ready;
        chk("din_ready", {63'd0, din_ready}, {63'd0, exp_rdy});
        chk("dout_valid", {56'd0, dout_valid}, {56'd0, m_vld});
        chk("dout_bus", dout_bus, model_bus());
        chk("ptr", {61'd0, ptr}, 64'(m_ptr));
        @(posedge clk);
        if (r) begin
            m_vld = '0;
            for (int k = 0; k < 8; k++) m_dat[k] = '0;
            m_ptr = 0;
        end else begin
            m_vld = m_vld & ~dr;
            if (dv && exp_rdy) begin
                m_vld[tgt] = 1'b1;
                m_dat[tgt] = d;
                if (ai) m_ptr = (m_ptr + 1) % 8;
            end
        end
        #1;
    endtask

    initial begin
        m_vld = '0;
        m_ptr = 0;
        for (int k = 0; k < 8; k++) m_dat[k] = '0;

        // Reset held with din_valid asserted
        cyc(1, 0, 1, 0, 8'h11, 1, 8'h00);
        chk("rst_ready", {63'd0, last_rdy}, 64'd0);
        cyc(1, 0, 1, 0, 8'h11, 1, 8'h00);
        chk("rst_valid", {56'd0, dout_valid}, 64'h00);
        chk("rst_ptr", {61'd0, ptr}, 64'd0);

        // Addressed write to channel 5, then stall until consumer 5 drains
        cyc(0, 0, 0, 3'd5, 8'hA5, 1, 8'h00);
        chk("addr_valid", {56'd0, dout_valid}, 64'h20);
        chk("addr_data", {56'd0, dout_bus[47:40]}, 64'hA5);
        cyc(0, 0, 0, 3'd5, 8'h5A, 1, 8'h00);
        chk("addr_stall", {63'd0, last_rdy}, 64'd0);
        cyc(0, 0, 0, 3'd5, 8'h5A, 1, 8'h20);
        chk("addr_refill_rdy", {63'd0, last_rdy}, 64'd1);
        chk("addr_refill", {56'd0, dout_bus[47:40]}, 64'h5A);
        chk("addr_ptr_held", {61'd0, ptr}, 64'd0);
        cyc(0, 0, 0, 3'd0, 8'h00, 0, 8'hFF);
        chk("addr_drained", {56'd0, dout_valid}, 64'h00);

        // Round-robin, ten words with every consumer ready
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 3'd7, 8'(i), 1, 8'hFF);
        chk("rr_ptr", {61'd0, ptr}, 64'd2);
        chk("rr_bus", dout_bus, 64'h07060504_03020908);
        chk("rr_valid", {56'd0, dout_valid}, 64'h02);

        // Back-pressure: fill all, stall, then refill ch0 in its drain cycle
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 8'h10 + 8'(i), 1, 8'h00);
        chk("bp_full", {56'd0, dout_valid}, 64'hFF);
        chk("bp_ptr", {61'd0, ptr}, 64'd0);
        cyc(0, 0, 1, 0, 8'h99, 1, 8'h00);
        chk("bp_stall", {63'd0, last_rdy}, 64'd0);
        cyc(0, 0, 1, 0, 8'h99, 1, 8'h01);
        chk("bp_nobubble_rdy", {63'd0, last_rdy}, 64'd1);
        chk("bp_nobubble", {56'd0, dout_valid}, 64'hFF);
        chk("bp_ch0", {56'd0, dout_bus[7:0]}, 64'h99);
        chk("bp_ptr1", {61'd0, ptr}, 64'd1);

        // Chip select high: no accepts, ch2 still drains
        cyc(0, 1, 1, 0, 8'h42, 1, 8'h04);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 8'h42, 1, 8'h00);
        chk("ncs_ptr", {61'd0, ptr}, 64'd1);
        chk("ncs_valid", {56'd0, dout_valid}, 64'hFB);
        chk("ncs_hold", {56'd0, dout_bus[23:16]}, 64'h12);

        // Reset mid-run with four words held
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 8'h30 + 8'(i), 1, 8'h00);
        chk("mid_valid", {56'd0, dout_valid}, 64'h0F);
        cyc(1, 0, 1, 0, 8'h55, 1, 8'h00);
        chk("mid_rst_valid", {56'd0, dout_valid}, 64'h00);
        chk("mid_rst_ptr", {61'd0, ptr}, 64'd0);
        cyc(0, 0, 1, 3'd6, 8'h77, 1, 8'h00);
        chk("post_rst_ch0", {56'd0, dout_bus[7:0]}, 64'h77);
        chk("post_rst_valid", {56'd0, dout_valid}, 64'h01);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                1'($urandom), 3'($urandom), 8'($urandom),
                ($urandom_range(0, 3) != 0), 8'($urandom & $urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_demux_8_reg

`default_nettype wire
